// File: rtl/alu_pkg.sv
// Shared constants, result type and saturating-add helper for the ALU result path.
package alu_pkg;

    localparam int ALU_C_W   = 6;
    localparam int ALU_AB_W  = 5;
    localparam int ALU_SUM_W = 10;

    typedef logic signed [ALU_C_W-1:0] alu_result_t;

    // Adds sample to sum and clamps the result to the signed range of a w-bit register.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] sum,
        input logic signed [31:0] sample,
        input int                 w = ALU_SUM_W
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = sum + sample;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (s > hi) begin
            sat_add = hi;
        end else if (s < lo) begin
            sat_add = lo;
        end else begin
            sat_add = s;
        end
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// First-word-fall-through FIFO with a registered head entry and wrap-bit pointers.
module alu_sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic [AW-1:0]    rd_addr_next;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = LW'(wr_ptr_reg - rd_ptr_reg);

    assign rd_ok        = rd_en && !empty;
    assign wr_ok        = wr_en && (!full || rd_ok);
    assign rd_addr_next = rd_ptr_reg[AW-1:0] + AW'(1);
    assign rd_data      = head_reg;

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // The head register is preloaded so the next entry is visible right after the popping edge.
    always_comb begin
        head_next = head_reg;
        if (empty) begin
            if (wr_ok) begin
                head_next = wr_data;
            end
        end else if (rd_ok) begin
            if (level == LW'(1)) begin
                if (wr_ok) begin
                    head_next = wr_data;
                end
            end else begin
                head_next = mem[rd_addr_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            head_reg <= head_next;
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Buffers valid ALU results for a valid/ready consumer and tracks a saturating sum and sample count.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int C_W   = ALU_C_W,
    parameter int SUM_W = ALU_SUM_W,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [C_W-1:0]        C,
    input  logic                         C_en,
    input  logic                         clear,
    output logic signed [C_W-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic signed [SUM_W-1:0]      sum,
    output logic [CNT_W-1:0]             sample_cnt,
    output logic                         overflow
);

    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [C_W-1:0]          head_data;
    logic signed [SUM_W-1:0] sum_reg;
    logic signed [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    overflow_reg;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = C_en && (!full || pop);

    alu_sync_fifo #(
        .WIDTH (C_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .wr_en   (push),
        .wr_data (C),
        .rd_en   (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_data = head_data;
    assign sum_next = SUM_W'(sat_add(32'(sum_reg), 32'(C), SUM_W));

    // A dropped sample (full, no pop) leaves sum and count untouched but latches overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg      <= '0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            sum_reg      <= '0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                sum_reg <= sum_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (C_en) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign sum        = sum_reg;
    assign sample_cnt = cnt_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed and random checks of alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;

    localparam int DEPTH = 8;
    localparam int SMAX  = 511;
    localparam int SMIN  = -512;

    logic              clk;
    logic              rst_n;
    logic signed [5:0] c_in;
    logic              c_en;
    logic              clear;
    logic signed [5:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic [3:0]        level;
    logic signed [9:0] sum;
    logic [15:0]       sample_cnt;
    logic              overflow;

    int n_checks;
    int n_fail;

    // reference model state
    int q[$];
    int m_sum;
    int m_cnt;
    int m_ovf;

    alu_result_collector #(
        .DEPTH (DEPTH),
        .C_W   (6),
        .SUM_W (10),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .C          (c_in),
        .C_en       (c_en),
        .clear      (clear),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .level      (level),
        .sum        (sum),
        .sample_cnt (sample_cnt),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what a FIFO of DEPTH entries with a saturating sum must hold after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 0;
        end else if (clear) begin
            q.delete();
            m_sum = 0;
            m_cnt = 0;
            m_ovf = 0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (q.size() > 0) && out_ready;
            do_push = c_en && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(int'(c_in));
                m_sum = m_sum + int'(c_in);
                if (m_sum > SMAX) m_sum = SMAX;
                if (m_sum < SMIN) m_sum = SMIN;
                m_cnt = (m_cnt + 1) % 65536;
            end else if (c_en) begin
                m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", int'(level), q.size());
            chk("out_valid", int'(out_valid), int'(q.size() > 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            if (q.size() > 0) chk("out_data", int'(out_data), q[0]);
            chk("sum", int'(sum), m_sum);
            chk("sample_cnt", int'(sample_cnt), m_cnt);
            chk("overflow", int'(overflow), m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        c_in      = '0;
        c_en      = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        tick();

        // burst of three while stalled, then drain
        c_en = 1'b1;
        c_in = 6'sd8;  tick();
        c_in = 6'sd10; tick();
        c_in = 6'sd12; tick();
        c_en = 1'b0;
        chk("burst_level", int'(level), 3);
        chk("burst_head", int'(out_data), 8);
        chk("burst_sum", int'(sum), 30);
        chk("burst_cnt", int'(sample_cnt), 3);
        out_ready = 1'b1;
        tick(); chk("pop1_head", int'(out_data), 10);
        tick(); chk("pop2_head", int'(out_data), 12);
        tick(); chk("drained_valid", int'(out_valid), 0);
        out_ready = 1'b0;

        // full without pop drops the sample
        do_clear();
        c_en = 1'b1;
        c_in = 6'sd1;
        repeat (DEPTH) tick();
        c_in = 6'sd5;
        tick();
        c_en = 1'b0;
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_level", int'(level), 8);
        chk("drop_sum", int'(sum), 8);
        chk("drop_cnt", int'(sample_cnt), 8);

        // full with simultaneous pop accepts the sample
        do_clear();
        c_en = 1'b1;
        c_in = 6'sd1;
        repeat (DEPTH) tick();
        c_in = 6'sd5;
        out_ready = 1'b1;
        tick();
        c_en = 1'b0;
        out_ready = 1'b0;
        chk("fullpop_level", int'(level), 8);
        chk("fullpop_overflow", int'(overflow), 0);
        chk("fullpop_sum", int'(sum), 13);

        // positive saturation, then recovery with a negative sample
        do_clear();
        c_en = 1'b1;
        out_ready = 1'b1;
        c_in = 6'sd31;
        repeat (40) tick();
        chk("sat_hi", int'(sum), 511);
        c_in = -6'sd32;
        tick();
        chk("sat_recover", int'(sum), 479);
        c_en = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0;

        // clear beats a simultaneous push
        do_clear();
        c_en = 1'b1;
        c_in = 6'sd1; tick();
        c_in = 6'sd2; tick();
        c_in = 6'sd3; tick();
        clear = 1'b1;
        c_in = 6'sd7;
        tick();
        clear = 1'b0;
        c_en = 1'b0;
        chk("clr_level", int'(level), 0);
        chk("clr_sum", int'(sum), 0);
        chk("clr_cnt", int'(sample_cnt), 0);
        chk("clr_valid", int'(out_valid), 0);
        tick();
        chk("clr_no7", int'(out_valid), 0);

        // asynchronous reset between edges
        c_en = 1'b1;
        c_in = 6'sd4; tick();
        c_in = 6'sd5; tick();
        c_in = 6'sd6; tick();
        c_in = 6'sd7; tick();
        c_en = 1'b0;
        chk("pre_rst_level", int'(level), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_full", int'(full), 0);
        chk("arst_sum", int'(sum), 0);
        chk("arst_cnt", int'(sample_cnt), 0);
        chk("arst_data", int'(out_data), 0);
        #3;
        rst_n = 1'b1;
        tick();
        c_en = 1'b1;
        c_in = -6'sd3;
        tick();
        c_en = 1'b0;
        chk("post_rst_data", int'(out_data), -3);
        chk("post_rst_sum", int'(sum), -3);

        // random traffic, checked every cycle by the model
        for (int i = 0; i < 2000; i++) begin
            c_en      = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 1) == 1);
            c_in      = 6'($urandom_range(0, 63));
            clear     = ($urandom_range(0, 199) == 0);
            tick();
        end
        c_en  = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
